// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with an
// optional post-reset scrub that writes zero to x1..x31 before any grant.
module rf_wb_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 64,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [5*NUM_REQ-1:0]      req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic                      rf_we,
    output logic [4:0]                rf_rd,
    output logic [DATA_W-1:0]         rf_data,
    output logic                      init_done,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a write transfers on a posedge where req_valid[i] & req_ready[i];
    // ready is a combinational grant, at most one bit, only in RUN.
    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_next;
    logic [4:0]         cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   ptr_next;
    logic               grant_any;
    logic [4:0]         sel_rd;
    logic [DATA_W-1:0]  sel_data;
    int                 idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT_ZERO ? INIT : RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && cnt == 5'd31) begin
            state_next = RUN;
        end
    end

    // Search upward from rr_ptr, wrapping, for the first valid requester.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        idx       = 0;
        req_ready = '0;
        if (state == RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    winner    = PTR_W'(idx);
                end
            end
        end
        if (grant_any) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_rd   = req_rd[5*i +: 5];
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
        ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= 5'd1;
            rr_ptr  <= '0;
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else if (state == INIT) begin
            rf_we   <= 1'b1;
            rf_rd   <= cnt;
            rf_data <= '0;
            cnt     <= cnt + 5'd1;
        end else if (grant_any) begin
            // rd=0 is consumed without a write; index and data still update.
            rf_we   <= (sel_rd != 5'd0);
            rf_rd   <= sel_rd;
            rf_data <= sel_data;
            rr_ptr  <= ptr_next;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    assign init_done = (state == RUN);
    assign busy      = (state == INIT);

endmodule
